// File: rtl/led_pkg.sv
// Shared definitions for the LED blinker control path.
//   CLOCK_FREQUENCY_DEFAULT : default system clock in Hz
//   RATE_MS                 : blink half-period table in milliseconds, index 0 is the default rate
//   HALF_PERIOD_W           : width of the blinker terminal-count bus
//   btn_state_e             : button debounce FSM state encoding
//   ms_to_count()           : milliseconds to clock cycles, done in 64-bit so 27 MHz * 500 ms fits
package led_pkg;

  localparam longint CLOCK_FREQUENCY_DEFAULT = 64'd27_000_000;

  localparam int NUM_RATES = 4;
  localparam longint RATE_MS [0:NUM_RATES-1] = '{64'd500, 64'd250, 64'd100, 64'd50};

  localparam int HALF_PERIOD_W = 24;
  localparam longint HALF_PERIOD_MAX = (64'd1 << HALF_PERIOD_W) - 64'd1;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } btn_state_e;

  function automatic longint ms_to_count(input longint freq_hz, input longint ms);
    return (freq_hz * ms) / 64'd1000;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronised output, two clk_i edges behind d_i
// RESET_VAL should be the inactive level of the input so that no spurious
// edge is seen when reset releases.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_rate_select.sv
// Push-button rate selector feeding the programmable LED blinker.
// Synchronises and debounces the raw button, steps a 4-entry blink-rate table
// on each accepted press, and returns to rate 0 on a long press.
//   Clock       : system clock
//   Reset_n     : asynchronous active-low reset
//   Button_in   : raw, bouncing pad input
//   Rate_index  : selected rate entry 0..3
//   Half_period : blinker terminal count (cycles per half period minus 1)
//   Period_load : one-cycle strobe, Half_period must be loaded downstream
//   Long_press  : one-cycle pulse on long-press detection
//
// state          | meaning
// ST_IDLE        | button released and stable
// ST_DEB_PRESS   | press seen, waiting for it to stay stable
// ST_HELD        | press accepted, timing the hold for long-press
// ST_DEB_RELEASE | release seen, waiting for it to stay stable
module button_rate_select
  import led_pkg::*;
#(
  parameter longint CLOCK_FREQUENCY   = CLOCK_FREQUENCY_DEFAULT,
  parameter longint DEBOUNCE_MS       = 20,
  parameter longint LONG_PRESS_MS     = 1000,
  parameter bit     BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Button_in,
  output logic [1:0]               Rate_index,
  output logic [HALF_PERIOD_W-1:0] Half_period,
  output logic                     Period_load,
  output logic                     Long_press
);

  localparam longint DEB_CNT  = ms_to_count(CLOCK_FREQUENCY, DEBOUNCE_MS);
  localparam longint LONG_CNT = ms_to_count(CLOCK_FREQUENCY, LONG_PRESS_MS);

  localparam int DEB_W  = (DEB_CNT  > 1) ? $clog2(DEB_CNT)  : 1;
  localparam int LONG_W = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

  localparam longint RATE_RAW0 = ms_to_count(CLOCK_FREQUENCY, RATE_MS[0]) - 1;
  localparam longint RATE_RAW1 = ms_to_count(CLOCK_FREQUENCY, RATE_MS[1]) - 1;
  localparam longint RATE_RAW2 = ms_to_count(CLOCK_FREQUENCY, RATE_MS[2]) - 1;
  localparam longint RATE_RAW3 = ms_to_count(CLOCK_FREQUENCY, RATE_MS[3]) - 1;

  localparam logic [HALF_PERIOD_W-1:0] RATE_CNT0 = HALF_PERIOD_W'(RATE_RAW0);
  localparam logic [HALF_PERIOD_W-1:0] RATE_CNT1 = HALF_PERIOD_W'(RATE_RAW1);
  localparam logic [HALF_PERIOD_W-1:0] RATE_CNT2 = HALF_PERIOD_W'(RATE_RAW2);
  localparam logic [HALF_PERIOD_W-1:0] RATE_CNT3 = HALF_PERIOD_W'(RATE_RAW3);

  if (RATE_RAW0 > HALF_PERIOD_MAX || RATE_RAW1 > HALF_PERIOD_MAX ||
      RATE_RAW2 > HALF_PERIOD_MAX || RATE_RAW3 > HALF_PERIOD_MAX ||
      RATE_RAW0 < 0 || RATE_RAW1 < 0 || RATE_RAW2 < 0 || RATE_RAW3 < 0) begin : g_rate_range_err
    $error("button_rate_select: blink rate count does not fit the Half_period bus");
  end

  if (DEB_CNT < 1 || LONG_CNT < 1) begin : g_timer_range_err
    $error("button_rate_select: debounce and long-press times must be at least one clock");
  end

  function automatic logic [HALF_PERIOD_W-1:0] rate_lut(input logic [1:0] idx);
    case (idx)
      2'd0:    rate_lut = RATE_CNT0;
      2'd1:    rate_lut = RATE_CNT1;
      2'd2:    rate_lut = RATE_CNT2;
      default: rate_lut = RATE_CNT3;
    endcase
  endfunction

  logic btn_sync;
  logic pressed;

  sync_2ff #(
    .RESET_VAL (BUTTON_ACTIVE_LOW)
  ) u_sync_btn (
    .clk_i  (Clock),
    .rst_ni (Reset_n),
    .d_i    (Button_in),
    .q_o    (btn_sync)
  );

  assign pressed = BUTTON_ACTIVE_LOW ? ~btn_sync : btn_sync;

  btn_state_e                 state_q, state_d;
  logic [DEB_W-1:0]           deb_q, deb_d;
  logic [LONG_W-1:0]          hold_q, hold_d;
  logic                       long_done_q, long_done_d;
  logic [1:0]                 idx_q, idx_d;
  logic [HALF_PERIOD_W-1:0]   half_q, half_d;
  logic                       load_q, load_d;
  logic                       long_q, long_d;
  logic                       started_q, started_d;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      idx_q       <= 2'd0;
      half_q      <= RATE_CNT0;
      load_q      <= 1'b0;
      long_q      <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      idx_q       <= idx_d;
      half_q      <= half_d;
      load_q      <= load_d;
      long_q      <= long_d;
      started_q   <= started_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    idx_d       = idx_q;
    half_d      = half_q;
    load_d      = 1'b0;
    long_d      = 1'b0;
    started_d   = 1'b1;

    // The first edge after reset pushes the default rate downstream.
    if (!started_q) begin
      load_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_DEB_PRESS;
          deb_d   = '0;
        end
      end

      ST_DEB_PRESS: begin
        if (!pressed) begin
          state_d = ST_IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d     = ST_HELD;
          idx_d       = idx_q + 2'd1;
          half_d      = rate_lut(idx_q + 2'd1);
          load_d      = 1'b1;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      ST_HELD: begin
        if (hold_q != LONG_LAST) begin
          hold_d = hold_q + LONG_W'(1);
        end
        // long_done keeps a saturated hold counter from re-firing.
        if (hold_q == LONG_LAST && !long_done_q) begin
          long_d      = 1'b1;
          load_d      = 1'b1;
          idx_d       = 2'd0;
          half_d      = RATE_CNT0;
          long_done_d = 1'b1;
        end
        if (!pressed) begin
          state_d = ST_DEB_RELEASE;
          deb_d   = '0;
        end
      end

      ST_DEB_RELEASE: begin
        // A bounce back to pressed resumes the hold without a new event.
        if (pressed) begin
          state_d = ST_HELD;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign Rate_index  = idx_q;
  assign Half_period = half_q;
  assign Period_load = load_q;
  assign Long_press  = long_q;

endmodule
